fft_agu: RTL and testbench

FFT_AGU -- requirements
Module: fft_agu

---
 rtl/fft_pkg.sv | 15 +
 rtl/fft_delay_line.sv | 25 ++
 rtl/fft_agu.sv | 134 +++++++++++++
 tb/tb_fft_agu.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - Default FFT geometry and AGU state encoding shared by the FFT address path.
package fft_pkg;

  localparam int FFT_N   = 512;
  localparam int FFT_M   = 9;
  localparam int FFT_LAT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_FIN   = 2'd3
  } agu_state_e;

endpackage

// File: rtl/fft_delay_line.sv
// rtl/fft_delay_line.sv - Fixed-depth register pipeline with synchronous clear.
module fft_delay_line #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) pipe_q[k] <= '0;
    end else begin
      pipe_q[0] <= din;
      for (int k = 1; k < DEPTH; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_agu.sv
// rtl/fft_agu.sv - In-place radix-2 FFT address generator with LAT-delayed write-back.
module fft_agu
  import fft_pkg::*;
#(
  parameter int N   = FFT_N,
  parameter int M   = FFT_M,
  parameter int LAT = FFT_LAT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic [M-1:0] adr_rd_a,
  output logic [M-1:0] adr_rd_b,
  output logic [M-2:0] tw_adr,
  output logic         rd_bank,
  output logic [M-1:0] adr_wr_a,
  output logic [M-1:0] adr_wr_b,
  output logic         we,
  output logic         wr_bank,
  output logic         busy,
  output logic         done
);

  localparam int SW = (M > 1) ? $clog2(M) : 1;
  localparam int IW = M - 1;
  localparam int FW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int DW = 2 * M + 2;
  localparam logic [IW-1:0] LAST_I  = IW'(N / 2 - 1);
  localparam logic [IW-1:0] TW_ONES = '1;

  agu_state_e     state_q, state_d;
  logic [SW-1:0]  stage_q, stage_d;
  logic [IW-1:0]  i_q, i_d;
  logic [FW-1:0]  flush_q, flush_d;
  logic           issue;
  logic [DW-1:0]  pipe_in, pipe_out;

  function automatic logic [M-1:0] rotl(input logic [M-1:0] x, input logic [SW-1:0] s);
    logic [2*M-1:0] t;
    t = {x, x} << s;
    return t[2*M-1:M];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
      i_q     <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      i_q     <= i_d;
      flush_q <= flush_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    i_d     = i_q;
    flush_d = flush_q;
    issue   = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = ST_RUN;
          stage_d = '0;
          i_d     = '0;
        end
      end
      ST_RUN: begin
        issue = 1'b1;
        if (i_q == LAST_I) begin
          state_d = ST_FLUSH;
          flush_d = '0;
        end else begin
          i_d = i_q + IW'(1);
        end
      end
      // Hold off the next stage until the last write of this stage has left the pipe.
      ST_FLUSH: begin
        if (flush_q == FW'(LAT - 1)) begin
          if (stage_q == SW'(M - 1)) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_RUN;
            stage_d = stage_q + SW'(1);
            i_d     = '0;
          end
        end else begin
          flush_d = flush_q + FW'(1);
        end
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    adr_rd_a = '0;
    adr_rd_b = '0;
    tw_adr   = '0;
    rd_bank  = 1'b0;
    if (issue) begin
      adr_rd_a = rotl({i_q, 1'b0}, stage_q);
      adr_rd_b = rotl({i_q, 1'b1}, stage_q);
      tw_adr   = i_q & (TW_ONES << (SW'(IW) - stage_q));
      rd_bank  = stage_q[0];
    end
  end

  // Write bank is stored pre-inverted and gated so idle slots stay all-zero.
  assign pipe_in = {issue, issue & ~stage_q[0], adr_rd_a, adr_rd_b};

  fft_delay_line #(
    .W     (DW),
    .DEPTH (LAT)
  ) u_wr_dly (
    .clk   (clk),
    .reset (reset),
    .din   (pipe_in),
    .dout  (pipe_out)
  );

  assign {we, wr_bank, adr_wr_a, adr_wr_b} = pipe_out;

endmodule

// File: tb/tb_fft_agu.sv
// tb/tb_fft_agu.sv - Randomised self-checking bench for fft_agu against a cycle-index model.
module tb_fft_agu;

  localparam int N     = 512;
  localparam int M     = 9;
  localparam int LAT   = 2;
  localparam int P     = N / 2 + LAT;
  localparam int TOTAL = M * P;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [M-1:0] adr_rd_a, adr_rd_b, adr_wr_a, adr_wr_b;
  logic [M-2:0] tw_adr;
  logic         rd_bank, wr_bank, we, busy, done;

  int tests = 0;
  int fails = 0;
  int mt    = 0;
  int we_cnt = 0;
  bit chk_en = 1'b0;

  typedef struct {
    int stg;
    bit bank;
  } pend_t;
  pend_t pend[$];

  fft_agu #(.N(N), .M(M), .LAT(LAT)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .adr_rd_a (adr_rd_a),
    .adr_rd_b (adr_rd_b),
    .tw_adr   (tw_adr),
    .rd_bank  (rd_bank),
    .adr_wr_a (adr_wr_a),
    .adr_wr_b (adr_wr_b),
    .we       (we),
    .wr_bank  (wr_bank),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic int rotl(int x, int s);
    return ((x << s) | (x >> (M - s))) & (N - 1);
  endfunction

  function automatic bit is_run(int t);
    return (t >= 1) && (t <= TOTAL) && (((t - 1) % P) < N / 2);
  endfunction

  task automatic check(string name, logic [31:0] act, int exp);
    tests++;
    if (act !== 32'(exp)) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (model cycle %0d)", name, act, exp, mt);
    end
  endtask

  // Model time: mt = cycles since start was accepted, 0 when idle.
  always @(posedge clk) begin
    if (reset) begin
      mt = 0;
      pend.delete();
    end else if (mt == 0) begin
      if (start) mt = 1;
    end else if (mt == TOTAL + 1) begin
      mt = 0;
    end else begin
      mt = mt + 1;
    end
  end

  always @(negedge clk) begin
    int s, i, wt, ws, wi;
    bit r, w, hit;
    if (chk_en) begin
      r  = is_run(mt);
      s  = (mt - 1) / P;
      i  = (mt - 1) % P;
      wt = mt - LAT;
      w  = (mt >= 1) && is_run(wt);
      ws = (wt - 1) / P;
      wi = (wt - 1) % P;
      check("busy", 32'(busy), int'(mt >= 1));
      check("done", 32'(done), int'(mt == TOTAL + 1));
      if (r) begin
        check("rd_a", 32'(adr_rd_a), rotl(2 * i, s));
        check("rd_b", 32'(adr_rd_b), rotl(2 * i + 1, s));
        check("tw_adr", 32'(tw_adr), (i >> (M - 1 - s)) << (M - 1 - s));
        check("rd_bank", 32'(rd_bank), s % 2);
      end else begin
        check("rd_idle", {adr_rd_a, adr_rd_b, tw_adr, rd_bank}, 0);
      end
      if (w) begin
        check("we", 32'(we), 1);
        check("wr_a", 32'(adr_wr_a), rotl(2 * wi, ws));
        check("wr_b", 32'(adr_wr_b), rotl(2 * wi + 1, ws));
        check("wr_bank", 32'(wr_bank), 1 - (ws % 2));
      end else begin
        check("wr_idle", {we, wr_bank, adr_wr_a, adr_wr_b}, 0);
      end
      if (we === 1'b1) begin
        we_cnt++;
        if (pend.size() > 0) void'(pend.pop_front());
      end
      if (r) begin
        hit = 1'b0;
        foreach (pend[k]) if (pend[k].stg < s && pend[k].bank == rd_bank) hit = 1'b1;
        check("bank_hazard", 32'(hit), 0);
        pend.push_back('{s, ~rd_bank});
      end
      // Hand-computed pins on the model itself.
      if (mt == 1) begin
        check("pin_s0i0_a", 32'(adr_rd_a), 0);
        check("pin_s0i0_b", 32'(adr_rd_b), 1);
        check("pin_s0i0_tw", 32'(tw_adr), 0);
        check("pin_s0i0_bank", 32'(rd_bank), 0);
      end
      if (mt == 2) begin
        check("pin_s0i1_a", 32'(adr_rd_a), 2);
        check("pin_s0i1_b", 32'(adr_rd_b), 3);
      end
      if (mt == P + 2) begin
        check("pin_s1i1_a", 32'(adr_rd_a), 4);
        check("pin_s1i1_b", 32'(adr_rd_b), 6);
        check("pin_s1i1_tw", 32'(tw_adr), 'h00);
      end
      if (mt == P + 129) check("pin_s1i128_tw", 32'(tw_adr), 'h80);
      if (mt == 8 * P + 6) begin
        check("pin_s8i5_tw", 32'(tw_adr), 5);
        check("pin_s8i5_bank", 32'(rd_bank), 0);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic run_full(bit noisy);
    int cyc;
    bit seen;
    repeat ($urandom_range(1, 5)) tick();
    we_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    seen = 1'b0;
    while (cyc < 3000 && !seen) begin
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (noisy) start = ($urandom_range(0, 7) == 0);
        tick();
        cyc++;
      end
    end
    start = 1'b0;
    check("done_seen", 32'(seen), 1);
    check("done_cycle", cyc, 2323);
    check("we_pulses", we_cnt, 2304);
    if (noisy) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      check("fin_start_ignored", 32'(busy), 0);
    end
  endtask

  initial begin
    int k, ndone;
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk);
    tick();
    chk_en = 1'b1;
    check("reset_outputs", {adr_rd_a, adr_rd_b, tw_adr, rd_bank, adr_wr_a, adr_wr_b, we, wr_bank, busy, done}, 0);
    tick();
    reset = 1'b0;

    run_full(1'b0);
    run_full(1'b1);

    // Abort at stage 3, i=100.
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (k < 3000 && mt != 3 * P + 101) begin
      tick();
      k++;
    end
    check("abort_point_rd_a", 32'(adr_rd_a), 67);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_we", 32'(we), 0);
    ndone = 0;
    repeat (20) begin
      tick();
      if (done === 1'b1 || we === 1'b1) ndone++;
    end
    check("abort_quiet", ndone, 0);
    run_full(1'b0);

    // Reset and start together, idle and mid-run.
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("rst_start_idle", 32'(busy), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat ($urandom_range(1, TOTAL)) tick();
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("rst_start_run", 32'(busy), 0);
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule
